// File: rtl/ckegen_pkg.sv
// ckegen_pkg: shared defaults and helpers for the multi-channel clock-enable generator
package ckegen_pkg;
  localparam int CNT_W_DEF = 26;
  function automatic logic [31:0] eff_div(input logic [31:0] d);
    return (d < 32'd1) ? 32'd1 : d;
  endfunction
  function automatic int sel_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction
endpackage

// File: rtl/ckegen_ch.sv
// ckegen_ch: one enable channel with programmable divisor, pulse and toggle outputs
module ckegen_ch
  import ckegen_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_data_i,
  output logic             gen_o,
  output logic             tgl_o
);
  logic [CNT_W-1:0] div_q, cnt_q, div_eff;
  logic             gen_q, tgl_q, wrap;
  assign div_eff = CNT_W'(eff_div(32'(div_q)));
  assign wrap    = cnt_q == div_eff - CNT_W'(1);
  assign gen_o   = gen_q;
  assign tgl_o   = tgl_q;
  // A stored 0 is kept as written; only the compare uses the effective divisor
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= CNT_W'(DEFAULT_DIV);
      cnt_q <= '0;
      gen_q <= 1'b0;
      tgl_q <= 1'b0;
    end else begin
      if (wr_i) div_q <= wr_data_i;
      if (clr_i) begin
        cnt_q <= '0;
        gen_q <= 1'b0;
        tgl_q <= 1'b0;
      end else if (wr_i) begin
        cnt_q <= '0;
        gen_q <= 1'b0;
      end else if (en_i) begin
        cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
        gen_q <= wrap;
        tgl_q <= tgl_q ^ wrap;
      end else begin
        gen_q <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/ckegen_multi.sv
// ckegen_multi: NCH independent clock-enable channels with shared sync and divisor write port
module ckegen_multi
  import ckegen_pkg::*;
#(
  parameter int          NCH         = 4,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = 50000000,
  localparam int         SEL_W       = sel_w(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             div_we,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [CNT_W-1:0] div_data,
  output logic [NCH-1:0]   gen,
  output logic [NCH-1:0]   tgl
);
  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("ckegen_multi: NCH must be 1..16");
  end
  if (64'(DEFAULT_DIV) >= (64'd1 << CNT_W)) begin : g_bad_div
    $error("ckegen_multi: DEFAULT_DIV does not fit in CNT_W bits");
  end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ckegen_ch #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en[i]),
      .clr_i     (sync),
      .wr_i      (div_we && div_sel == SEL_W'(i)),
      .wr_data_i (div_data),
      .gen_o     (gen[i]),
      .tgl_o     (tgl[i])
    );
  end
endmodule

// File: tb/tb_ckegen_multi.sv
// tb_ckegen_multi: randomized scoreboard bench against a pulse-count reference model
module tb_ckegen_multi;
  localparam int NCH = 3;
  localparam int CNT_W = 8;
  localparam int DEF = 4;
  localparam int SEL_W = 2;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NCH-1:0]   en = '0;
  logic             sync = 1'b0;
  logic             div_we = 1'b0;
  logic [SEL_W-1:0] div_sel = '0;
  logic [CNT_W-1:0] div_data = '0;
  logic [NCH-1:0]   gen, tgl;
  int checks = 0;
  int errors = 0;
  int unsigned mdiv [NCH];
  int unsigned pos [NCH];
  bit          base [NCH];
  logic [2*NCH-1:0] expq [$];

  ckegen_multi #(.NCH(NCH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .div_we(div_we),
    .div_sel(div_sel), .div_data(div_data), .gen(gen), .tgl(tgl)
  );

  always #5 clk = ~clk;

  // Model: pos counts enabled edges since the last clear; a pulse lands on every multiple of
  // the effective divisor, and tgl is the pulse-count parity on top of the level held at clear.
  function automatic int unsigned deff(int i);
    return (mdiv[i] == 0) ? 1 : mdiv[i];
  endfunction
  function automatic bit mtgl(int i);
    return base[i] ^ bit'((pos[i] / deff(i)) & 1);
  endfunction

  task automatic step(bit r, logic [NCH-1:0] e, bit s, bit w, int sel, int d);
    logic [NCH-1:0] g, t;
    @(negedge clk);
    rst = r; en = e; sync = s; div_we = w; div_sel = SEL_W'(sel); div_data = CNT_W'(d);
    for (int i = 0; i < NCH; i++) begin
      bit wr_i, t_old;
      wr_i = w && (sel == i);
      t_old = mtgl(i);
      g[i] = 1'b0;
      if (r) begin
        mdiv[i] = DEF; pos[i] = 0; base[i] = 0;
      end else begin
        if (wr_i) mdiv[i] = d;
        if (s) begin
          pos[i] = 0; base[i] = 0;
        end else if (wr_i) begin
          pos[i] = 0; base[i] = t_old;
        end else if (e[i]) begin
          pos[i]++;
          g[i] = (pos[i] % deff(i)) == 0;
        end
      end
      t[i] = mtgl(i);
    end
    expq.push_back({g, t});
  endtask

  task automatic run(int n, logic [NCH-1:0] e);
    for (int k = 0; k < n; k++) step(0, e, 0, 0, 0, 0);
  endtask

  task automatic check_div(string name, int ch, int want);
    logic [CNT_W-1:0] got;
    @(posedge clk); #1;
    got = (ch == 0) ? dut.g_ch[0].u_ch.div_q : (ch == 1) ? dut.g_ch[1].u_ch.div_q : dut.g_ch[2].u_ch.div_q;
    checks++;
    if (got !== CNT_W'(want)) begin
      errors++;
      $display("FAIL %s: div_q=%0d expected %0d", name, got, want);
    end
  endtask

  initial begin : monitor
    logic [2*NCH-1:0] x;
    forever begin
      @(posedge clk); #1;
      if (expq.size() > 0) begin
        x = expq.pop_front();
        checks += 2;
        if (gen !== x[2*NCH-1:NCH]) begin
          errors++;
          $display("FAIL gen @%0t: got %b expected %b", $time, gen, x[2*NCH-1:NCH]);
        end
        if (tgl !== x[NCH-1:0]) begin
          errors++;
          $display("FAIL tgl @%0t: got %b expected %b", $time, tgl, x[NCH-1:0]);
        end
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < NCH; i++) begin mdiv[i] = DEF; pos[i] = 0; base[i] = 0; end
    step(1, '0, 0, 0, 0, 0);
    step(1, '0, 0, 0, 0, 0);
    run(14, 3'b111);
    step(0, 3'b111, 0, 1, 0, 3);
    step(0, 3'b111, 0, 1, 1, 5);
    run(20, 3'b111);
    step(0, 3'b111, 1, 0, 0, 0);
    run(20, 3'b111);
    step(0, 3'b111, 0, 1, 0, 0);
    run(5, 3'b111);
    step(0, 3'b111, 0, 1, 0, 1);
    check_div("div_one_readback", 0, 1);
    run(5, 3'b111);
    step(0, 3'b111, 0, 1, 0, 4);
    run(2, 3'b111);
    run(10, 3'b110);
    run(6, 3'b111);
    step(0, 3'b111, 1, 1, 1, 6);
    check_div("sync_write_div", 1, 6);
    run(7, 3'b111);
    step(1, 3'b111, 1, 0, 0, 0);
    check_div("reset_div_default", 1, DEF);
    run(9, 3'b111);
    step(0, 3'b111, 0, 1, 3, 1);
    run(12, 3'b111);
    check_div("invalid_sel_ch2", 2, DEF);
    for (int k = 0; k < 2000; k++) begin
      bit r, s, w;
      r = ($urandom_range(299) == 0);
      s = ($urandom_range(39) == 0);
      w = ($urandom_range(24) == 0);
      step(r, NCH'($urandom_range(7) | ($urandom_range(3) == 0 ? 0 : 7)), s, w,
           $urandom_range(3), $urandom_range(7));
    end
    step(0, 3'b111, 0, 0, 0, 0);
    for (int k = 0; k < 5 && expq.size() > 0; k++) @(posedge clk);
    #2;
    if (expq.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expected entries left", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
